// File: rtl/i2c_slave_responder_if.sv
// rtl/i2c_slave_responder_if.sv - I2C bus pins (SCL, SDA in, SDA pull-down enable)
interface i2c_slave_responder_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport slave (
    input  scl,
    input  sda_in,
    output sda_oe
  );

  modport master (
    output scl,
    output sda_in,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C slave with sub-address register pointer, byte write and sequential read
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5C
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_slave_responder_if.slave   bus,
  output logic [7:0]             reg_addr,
  output logic [7:0]             reg_wdata,
  output logic                   reg_we,
  input  logic [7:0]             reg_rdata,
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic        start_evt, stop_evt;
  logic        scl_rise, scl_fall;
  logic        start_seen, stop_seen;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        rw_q, rw_d;
  logic        ack_seen_q, ack_seen_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic [7:0]  byte_in;

  // Two-flop synchronizers plus one delayed copy of each for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= bus.sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  // SCL must be stably high across the SDA edge for a bus condition.
  assign start_seen = sda_d & ~sda_s2 & scl_s2 & scl_d;
  assign stop_seen  = ~sda_d & sda_s2 & scl_s2 & scl_d;

  // START/STOP are flagged one clock after the SDA transition is observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_evt <= 1'b0;
      stop_evt  <= 1'b0;
    end else begin
      start_evt <= start_seen;
      stop_evt  <= stop_seen;
    end
  end

  assign byte_in = {shift_q[6:0], sda_s2};

  // Next-state and datapath: bytes shift in on SCL rise, SDA changes only on SCL fall.
  always_comb begin
    state_d     = state_q;
    sda_oe_d    = sda_oe_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    ack_seen_d  = ack_seen_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;

    // Pointer advances the cycle after the write strobe, so the strobe sees the old address.
    if (reg_we_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end

    if (stop_evt) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 3'd0;
      ack_seen_d = 1'b0;
    end else if (start_evt) begin
      state_d    = ADDR;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 3'd0;
      shift_d    = 8'h00;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: begin
          sda_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw_d    = byte_in[0];
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        SUB: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_addr_d = byte_in;
              state_d    = SUB_ACK;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_wdata_d = byte_in;
              reg_we_d    = 1'b1;
              state_d     = WDATA_ACK;
            end
          end
        end

        // The registered sda_oe tells which of the two ACK falling edges this is.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                state_d  = RDATA;
                shift_d  = reg_rdata;
                sda_oe_d = ~reg_rdata[7];
              end else begin
                state_d  = SUB;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = WDATA;
            end
          end
        end

        // Shift on rise so the next bit sits in shift_q[7] for the following fall.
        RDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = RDATA_ACK;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end

        // First fall releases SDA, rise samples the master, second fall loads the next byte.
        RDATA_ACK: begin
          if (scl_fall) begin
            if (ack_seen_q) begin
              ack_seen_d = 1'b0;
              bit_cnt_d  = 3'd0;
              shift_d    = reg_rdata;
              sda_oe_d   = ~reg_rdata[7];
              state_d    = RDATA;
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (scl_rise) begin
            if (!sda_s2) begin
              reg_addr_d = reg_addr_q + 8'd1;
              ack_seen_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; async reset releases SDA at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sda_oe_q    <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rw_q        <= 1'b0;
      ack_seen_q  <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sda_oe_q    <= sda_oe_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rw_q        <= rw_d;
      ack_seen_q  <= ack_seen_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  // Busy only once the address has matched; an unmatched transfer never shows busy.
  assign busy       = (state_q != IDLE) && (state_q != ADDR) && (state_q != IGNORE);

endmodule
